cmos_ram_arbiter: RTL and testbench
===================================

// Module: cmos_ram_arbiter
// PURPOSE
//   Shares the 1024x4 battery-backed CMOS RAM between the game CPU and a host
//   maintenance port (save/restore of high scores and settings). Runs a
//   single-access sequencer with a one-cycle RAM read latency. Applies CPU write
//   protection and keeps a dirty flag so the host can decide when to snapshot.
//   Sits between the CPU bus decode and the CMOS RAM instance.
// PARAMETERS
//   MAX_CPU_BURST  4      consecutive CPU grants allowed while host pends (1..15)
//   PROTECT_LIMIT  10'h100 CPU writes to addr < this are blocked when cpu_wprot=1
// PORTS
//   clk            in   1   system clock, all logic on rising edge
//   reset          in   1   asynchronous, active-high reset
//   cpu_req        in   1   CPU access request, held until cpu_ack
//   cpu_we         in   1   1=write, 0=read; stable while cpu_req
//   cpu_addr       in   10  nibble address; stable while cpu_req
//   cpu_wdata      in   4   write nibble
//   cpu_wprot      in   1   1=coin door closed, low region write-protected
//   cpu_ack        out  1   one-cycle completion pulse
//   cpu_rdata      out  4   read nibble, valid while cpu_ack, held after
//   host_req/host_we/host_addr[9:0]/host_wdata[3:0]  in  same rules as CPU
//   host_ack       out  1   one-cycle completion pulse
//   host_rdata     out  4   read nibble, valid while host_ack, held after
//   host_clr_dirty in   1   pulse: clear dirty flag
//   dirty          out  1   1=CPU has completed an unblocked write since clear
//   ram_cs         out  1   to RAM cs (registered)
//   ram_we         out  1   to RAM we (registered)
//   ram_addr       out  10  to RAM addr (registered)
//   ram_din        out  4   to RAM data_in (registered)
//   ram_dout       in   4   from RAM data_out (registered in RAM, 1-cycle)
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, burst counter 0, rdata regs 0, dirty 0.
//   FSM: IDLE -> ISSUE -> READ -> DONE -> IDLE; one access per 4 cycles.
//   - IDLE: if any req sampled high, pick winner, register ram_* (cs=1), ->ISSUE.
//   - ISSUE: ram_cs/ram_we deassert (0); RAM performs access at this edge; ->READ.
//   - READ: capture ram_dout into winner's rdata if read; winner ack<=1; ->DONE.
//   - DONE: ack<=0; ->IDLE unconditionally (req not sampled, allows requester
//     to drop req). Latency: req seen at edge E0 -> ack high E2..E3.
//   Arbitration in IDLE: CPU has priority. Burst counter increments on each CPU
//   grant while host_req=1; when counter==MAX_CPU_BURST and host_req=1, host
//   wins and counter clears. Counter clears whenever host is granted or
//   host_req=0 in IDLE.
//   Write protect: CPU write with cpu_wprot=1 and cpu_addr<PROTECT_LIMIT runs the
//   full FSM and is acked, but ram_cs stays 0 (RAM untouched, dirty unchanged).
//   Host writes are never protected.
//   Dirty: set in READ on a CPU write that drove ram_cs=1. Set and
//   host_clr_dirty in same cycle -> dirty stays 1 (set wins).
//   rdata regs update only on reads; writes leave previous value.
//   Req dropped before ack: access still completes and acks (no abort).
//   Reset mid-access: FSM to IDLE immediately, no ack, RAM write not issued if
//   reset precedes the ISSUE edge.
// TESTING
//   Reset then CPU write 0x5 @0x200 -> ram_cs=1,we=1 one cycle; cpu_ack E2; dirty=1.
//   CPU read @0x200 -> cpu_rdata=0x5 with cpu_ack, 3 edges after req sampled.
//   cpu_wprot=1, CPU write 0xA @0x0FF -> cpu_ack, ram_cs never 1, dirty unchanged;
//     same at @0x100 -> written.
//   CPU and host both req continuously, MAX_CPU_BURST=4 -> grants CPU x4, host x1,
//     repeat; host_rdata correct per host_addr.
//   host_clr_dirty coincident with CPU write completion -> dirty=1 after edge.
//   Assert reset during READ -> no ack, all outputs 0; next request served normally.

Source files
------------

// File: rtl/cmos_ram_arbiter_if.sv
// cmos_ram_arbiter_if
//   Bus bundle between the CMOS RAM arbiter, its two requesters (game CPU and
//   host maintenance port) and the 1024x4 CMOS RAM.
//   cpu_*  : CPU request/ack handshake, address, write data, read data, wprot
//   host_* : host request/ack handshake, address, write data, read data,
//            plus host_clr_dirty pulse and the dirty status flag
//   ram_*  : registered RAM strobes/address/data out, RAM read data in
//   Modports: slave = arbiter side, master = requesters + RAM side.
interface cmos_ram_arbiter_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [9:0] cpu_addr;
  logic [3:0] cpu_wdata;
  logic       cpu_wprot;
  logic       cpu_ack;
  logic [3:0] cpu_rdata;

  logic       host_req;
  logic       host_we;
  logic [9:0] host_addr;
  logic [3:0] host_wdata;
  logic       host_ack;
  logic [3:0] host_rdata;
  logic       host_clr_dirty;
  logic       dirty;

  logic       ram_cs;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic [3:0] ram_din;
  logic [3:0] ram_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wprot,
    output cpu_ack, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata, host_clr_dirty,
    output host_ack, host_rdata, dirty,
    output ram_cs, ram_we, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wprot,
    input  cpu_ack, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata, host_clr_dirty,
    input  host_ack, host_rdata, dirty,
    input  ram_cs, ram_we, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/cmos_ram_arbiter.sv
// cmos_ram_arbiter
//   Shares the 1024x4 battery-backed CMOS RAM between the game CPU and the host
//   maintenance port. One access at a time through IDLE->ISSUE->READ->DONE
//   (4 cycles per access, RAM read latency of one cycle). CPU has priority but
//   the host is guaranteed a slot after MAX_CPU_BURST consecutive CPU grants.
//   CPU writes below PROTECT_LIMIT are dropped (still acked) while cpu_wprot=1.
//   A dirty flag records unblocked CPU writes since the last host_clr_dirty.
// Ports
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : cmos_ram_arbiter_if.slave (CPU, host and RAM signals)
module cmos_ram_arbiter #(
  parameter logic [3:0] MAX_CPU_BURST = 4'd4,
  parameter logic [9:0] PROTECT_LIMIT = 10'h100
) (
  input logic             clk,
  input logic             reset,
  cmos_ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_r;
  logic [3:0] burst_cnt_r;
  logic       win_host_r;
  logic       win_we_r;
  logic       win_live_r;   // access actually reached the RAM (not write-protected)
  logic       cpu_ack_r;
  logic [3:0] cpu_rdata_r;
  logic       host_ack_r;
  logic [3:0] host_rdata_r;
  logic       dirty_r;
  logic       ram_cs_r;
  logic       ram_we_r;
  logic [9:0] ram_addr_r;
  logic [3:0] ram_din_r;

  logic       any_req_s;
  logic       grant_host_s;
  logic       sel_we_s;
  logic [9:0] sel_addr_s;
  logic [3:0] sel_wdata_s;
  logic       blocked_s;
  logic       set_dirty_s;

  // Winner selection and write-protect decode for the IDLE sampling edge.
  always_comb begin
    any_req_s    = bus.cpu_req | bus.host_req;
    grant_host_s = 1'b0;
    sel_we_s     = 1'b0;
    sel_addr_s   = 10'd0;
    sel_wdata_s  = 4'd0;
    blocked_s    = 1'b0;
    // Host wins when the CPU is idle or has used up its burst allowance.
    if (bus.host_req && (!bus.cpu_req || (burst_cnt_r >= MAX_CPU_BURST))) begin
      grant_host_s = 1'b1;
    end else begin
      grant_host_s = 1'b0;
    end
    if (grant_host_s) begin
      sel_we_s    = bus.host_we;
      sel_addr_s  = bus.host_addr;
      sel_wdata_s = bus.host_wdata;
      blocked_s   = 1'b0;
    end else begin
      sel_we_s    = bus.cpu_we;
      sel_addr_s  = bus.cpu_addr;
      sel_wdata_s = bus.cpu_wdata;
      blocked_s   = bus.cpu_we & bus.cpu_wprot & (bus.cpu_addr < PROTECT_LIMIT);
    end
  end

  // Dirty is set by a completed CPU write that really reached the RAM.
  always_comb begin
    if ((state_r == READ) && !win_host_r && win_we_r && win_live_r) begin
      set_dirty_s = 1'b1;
    end else begin
      set_dirty_s = 1'b0;
    end
  end

  // Access sequencer: arbitration, RAM strobes, read capture and ack pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      burst_cnt_r  <= 4'd0;
      win_host_r   <= 1'b0;
      win_we_r     <= 1'b0;
      win_live_r   <= 1'b0;
      cpu_ack_r    <= 1'b0;
      cpu_rdata_r  <= 4'd0;
      host_ack_r   <= 1'b0;
      host_rdata_r <= 4'd0;
      ram_cs_r     <= 1'b0;
      ram_we_r     <= 1'b0;
      ram_addr_r   <= 10'd0;
      ram_din_r    <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            win_host_r <= grant_host_s;
            win_we_r   <= sel_we_s;
            win_live_r <= ~blocked_s;
            ram_cs_r   <= ~blocked_s;
            ram_we_r   <= sel_we_s & ~blocked_s;
            ram_addr_r <= sel_addr_s;
            ram_din_r  <= sel_wdata_s;
            // Only CPU grants made while the host waits count toward the burst.
            if (grant_host_s || !bus.host_req) begin
              burst_cnt_r <= 4'd0;
            end else begin
              burst_cnt_r <= burst_cnt_r + 4'd1;
            end
            state_r <= ISSUE;
          end else begin
            burst_cnt_r <= 4'd0;
            state_r     <= IDLE;
          end
        end
        ISSUE: begin
          // RAM latches the access on this edge; strobes drop for the next cycle.
          ram_cs_r <= 1'b0;
          ram_we_r <= 1'b0;
          state_r  <= READ;
        end
        READ: begin
          if (win_host_r) begin
            host_ack_r <= 1'b1;
            if (!win_we_r) begin
              host_rdata_r <= bus.ram_dout;
            end
          end else begin
            cpu_ack_r <= 1'b1;
            if (!win_we_r) begin
              cpu_rdata_r <= bus.ram_dout;
            end
          end
          state_r <= DONE;
        end
        DONE: begin
          // Requests are ignored here so a requester can drop req after ack.
          cpu_ack_r  <= 1'b0;
          host_ack_r <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          cpu_ack_r  <= 1'b0;
          host_ack_r <= 1'b0;
          ram_cs_r   <= 1'b0;
          ram_we_r   <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // Dirty flag: a same-cycle set beats host_clr_dirty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dirty_r <= 1'b0;
    end else if (set_dirty_s) begin
      dirty_r <= 1'b1;
    end else if (bus.host_clr_dirty) begin
      dirty_r <= 1'b0;
    end else begin
      dirty_r <= dirty_r;
    end
  end

  assign bus.cpu_ack    = cpu_ack_r;
  assign bus.cpu_rdata  = cpu_rdata_r;
  assign bus.host_ack   = host_ack_r;
  assign bus.host_rdata = host_rdata_r;
  assign bus.dirty      = dirty_r;
  assign bus.ram_cs     = ram_cs_r;
  assign bus.ram_we     = ram_we_r;
  assign bus.ram_addr   = ram_addr_r;
  assign bus.ram_din    = ram_din_r;

endmodule

// File: tb/tb_cmos_ram_arbiter.sv
// tb_cmos_ram_arbiter
//   Directed bench for cmos_ram_arbiter with a behavioural 1024x4 RAM
//   (one-cycle registered read). Inputs change and outputs are sampled on the
//   falling clock edge.
module tb_cmos_ram_arbiter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  cmos_ram_arbiter_if bus ();

  cmos_ram_arbiter #(
    .MAX_CPU_BURST (4'd4),
    .PROTECT_LIMIT (10'h100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0] mem [0:1023] = '{default: 4'h0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CMOS RAM: write on cs&we, registered read data.
  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_addr];
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {5'd0, bus.cpu_ack, bus.cpu_rdata, bus.host_ack, bus.host_rdata,
            bus.dirty, bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_din};
  endfunction

  // One complete access; lat counts edges from the sampling edge to ack seen.
  task automatic do_op(input logic host, input logic we, input logic [9:0] addr,
                       input logic [3:0] wd, input logic prot, input int clr_at,
                       output int lat, output int cs_cnt, output int we_cnt);
    @(negedge clk);
    bus.cpu_wprot = prot;
    if (host) begin
      bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wd;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    end
    lat = 0; cs_cnt = 0; we_cnt = 0;
    while (lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      bus.host_clr_dirty = (lat == clr_at);
      if (bus.ram_cs) cs_cnt++;
      if (bus.ram_we) we_cnt++;
      if (host ? bus.host_ack : bus.cpu_ack) break;
    end
    bus.cpu_req = 1'b0;
    bus.host_req = 1'b0;
    bus.host_clr_dirty = 1'b0;
  endtask

  initial begin
    int lat, cs_cnt, we_cnt, grants, h_idx, acks;
    logic [9:0] seq;
    logic [9:0] h_addr [2];
    logic [3:0] h_exp [2];
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 10'd0; bus.cpu_wdata = 4'd0;
    bus.cpu_wprot = 1'b0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = 10'd0; bus.host_wdata = 4'd0;
    bus.host_clr_dirty = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_vec(), 32'd0);
    reset = 1'b0;

    // CPU write 5 @0x200
    do_op(1'b0, 1'b1, 10'h200, 4'h5, 1'b0, 0, lat, cs_cnt, we_cnt);
    chk("wr_latency", lat, 32'd3);
    chk("wr_cs_cycles", cs_cnt, 32'd1);
    chk("wr_we_cycles", we_cnt, 32'd1);
    chk("wr_dirty", bus.dirty, 32'd1);
    chk("wr_mem", mem[10'h200], 32'h5);
    @(negedge clk);
    chk("wr_ack_pulse", bus.cpu_ack, 32'd0);

    // CPU read @0x200
    do_op(1'b0, 1'b0, 10'h200, 4'h0, 1'b0, 0, lat, cs_cnt, we_cnt);
    chk("rd_latency", lat, 32'd3);
    chk("rd_data", bus.cpu_rdata, 32'h5);
    chk("rd_cs_cycles", cs_cnt, 32'd1);
    chk("rd_we_cycles", we_cnt, 32'd0);
    @(negedge clk);
    chk("rd_data_hold", bus.cpu_rdata, 32'h5);

    // Clear dirty, then write-protect boundary
    bus.host_clr_dirty = 1'b1;
    @(negedge clk);
    bus.host_clr_dirty = 1'b0;
    chk("clr_dirty", bus.dirty, 32'd0);
    do_op(1'b0, 1'b1, 10'h0FF, 4'hA, 1'b1, 0, lat, cs_cnt, we_cnt);
    chk("prot_latency", lat, 32'd3);
    chk("prot_cs_cycles", cs_cnt, 32'd0);
    chk("prot_dirty", bus.dirty, 32'd0);
    chk("prot_mem", mem[10'h0FF], 32'h0);
    chk("prot_rdata_kept", bus.cpu_rdata, 32'h5);
    do_op(1'b0, 1'b1, 10'h100, 4'hA, 1'b1, 0, lat, cs_cnt, we_cnt);
    chk("limit_cs_cycles", cs_cnt, 32'd1);
    chk("limit_dirty", bus.dirty, 32'd1);
    chk("limit_mem", mem[10'h100], 32'hA);

    // Host write is never protected and does not set dirty
    bus.host_clr_dirty = 1'b1;
    @(negedge clk);
    bus.host_clr_dirty = 1'b0;
    do_op(1'b1, 1'b1, 10'h010, 4'h3, 1'b1, 0, lat, cs_cnt, we_cnt);
    chk("host_wr_latency", lat, 32'd3);
    chk("host_wr_cs", cs_cnt, 32'd1);
    chk("host_wr_mem", mem[10'h010], 32'h3);
    chk("host_wr_dirty", bus.dirty, 32'd0);

    // host_clr_dirty coincident with dirty set: set wins
    do_op(1'b0, 1'b1, 10'h201, 4'h6, 1'b0, 2, lat, cs_cnt, we_cnt);
    chk("set_beats_clr", bus.dirty, 32'd1);

    // Both requesters continuous: expect C C C C H C C C C H
    h_addr[0] = 10'h010; h_exp[0] = 4'h3;
    h_addr[1] = 10'h100; h_exp[1] = 4'hA;
    @(negedge clk);
    bus.cpu_wprot = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h200;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = h_addr[0];
    seq = 10'd0; grants = 0; h_idx = 0;
    for (int cyc = 0; cyc < 80 && grants < 10; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.cpu_ack) begin
        seq = {seq[8:0], 1'b0};
        grants++;
        chk("arb_cpu_rdata", bus.cpu_rdata, 32'h5);
      end
      if (bus.host_ack) begin
        seq = {seq[8:0], 1'b1};
        grants++;
        if (h_idx < 2) chk("arb_host_rdata", bus.host_rdata, h_exp[h_idx]);
        h_idx++;
        if (h_idx < 2) bus.host_addr = h_addr[h_idx];
      end
    end
    bus.cpu_req = 1'b0;
    bus.host_req = 1'b0;
    chk("arb_grants", grants, 32'd10);
    chk("arb_sequence", seq, 32'b0000100001);

    // Reset before the ISSUE edge: write never reaches RAM
    repeat (4) @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h220; bus.cpu_wdata = 4'hF;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_issue_outputs", outs_vec(), 32'd0);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_issue_mem", mem[10'h220], 32'h0);

    // Reset during READ: no ack, outputs cleared
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h230; bus.cpu_wdata = 4'h9;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_read_outputs", outs_vec(), 32'd0);
    bus.cpu_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      reset = 1'b0;
      if (bus.cpu_ack) acks++;
    end
    chk("rst_read_no_ack", acks, 32'd0);

    // Normal service after reset
    do_op(1'b0, 1'b0, 10'h200, 4'h0, 1'b0, 0, lat, cs_cnt, we_cnt);
    chk("post_rst_latency", lat, 32'd3);
    chk("post_rst_rdata", bus.cpu_rdata, 32'h5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
